tdm_demux: RTL
==============

// Module: tdm_demux
//
// PURPOSE
//   Receive end of a time-division-multiplexed channel stream: the inverse of
//   the mux-based channel selector. The transmitter sends one channel sample
//   per valid cycle, with channel 0 marked by start-of-frame.
//   This block steers each sample into its channel slot. When a frame is
//   complete it presents all N_CH samples in parallel, with a one-cycle strobe.
//   It sits between a serial TDM link and per-channel consumers.
//
// PARAMETERS
//   N_CH   4   number of channels per frame (legal range >= 2)
//   WIDTH  8   bits per channel sample
//
// PORTS
//   clk        input   1            clock, all logic on posedge
//   rst        input   1            synchronous reset, active-high
//   in_valid   input   1            in_data/in_sof carry a sample this cycle
//   in_sof     input   1            sample is channel 0 (start of frame)
//   in_data    input   WIDTH        channel sample
//   out_valid  output  1            one-cycle strobe: out_data holds a new frame
//   out_data   output  N_CH*WIDTH   frame; ch k at [k*WIDTH +: WIDTH], ch0 = LSBs
//   err_short  output  1            one-cycle pulse: in_sof arrived before frame done
//   err_unfr   output  1            one-cycle pulse: non-sof sample while not in a frame
//
// BEHAVIOUR
//   - Reset: state IDLE, slot counter 0, staging regs 0.
//     Outputs after reset: out_valid 0, out_data 0, err_short 0, err_unfr 0.
//   - Slot counter width: $clog2(N_CH).
//   - Staging register bank holds a partial frame. out_data is a separate
//     register and changes only on frame completion; it holds between frames.
//   - FSM states: IDLE, COLLECT. Cycles with in_valid=0 change nothing in
//     either state; gaps between slots are allowed.
//   - IDLE, in_valid & in_sof: stage[0] <= in_data, slot <= 1, go to COLLECT.
//   - IDLE, in_valid & !in_sof: sample dropped, err_unfr pulses next cycle.
//   - COLLECT, in_valid & !in_sof: stage[slot] <= in_data.
//     - If slot != N_CH-1: slot++.
//     - If slot == N_CH-1 (frame complete): out_data <= {in_data, stage[N_CH-2:0]},
//       out_valid pulses next cycle, slot <= 0, go to IDLE.
//   - COLLECT, in_valid & in_sof (short frame): err_short pulses next cycle.
//     Partial frame discarded, out_data unchanged, no out_valid.
//     Restart: stage[0] <= in_data, slot <= 1, stay in COLLECT.
//   - Latency: out_valid and the new out_data appear 1 cycle after the clock
//     edge that samples the last slot.
//   - Back-to-back: an in_sof on the cycle right after completion is accepted
//     (in IDLE). out_valid of the old frame and the capture of the new ch0
//     occur in the same cycle. Sustained throughput is one frame per N_CH cycles.
//   - Pulse length: err_short, err_unfr and out_valid are registered and each
//     lasts exactly one cycle per event.
//   - Reset mid-frame: partial frame lost, all outputs return to reset values.
//   - in_sof with in_valid=0 is ignored.
//
// TESTING  (N_CH=4, WIDTH=8)
//   1. sof+00,01,02,03 on 4 consecutive cycles -> next cycle out_valid=1 for
//      1 cycle, out_data=32'h03020100.
//   2. Same frame with 2 idle cycles between each slot -> single out_valid,
//      out_data=32'h03020100; no error pulses.
//   3. sof+AA,BB then sof+10,11,12,13 -> err_short 1 cycle after 2nd sof;
//      then out_valid with out_data=32'h13121110; no frame ever shows AA/BB.
//   4. 3 frames back-to-back, no gaps -> out_valid every 4 cycles; out_data
//      matches each frame in order.
//   5. Non-sof sample 55 right after reset -> err_unfr 1 cycle, out_valid stays
//      0, out_data stays 0.
//   6. rst=1 for 1 cycle after slot 2 of a frame; then a full frame 20..23 ->
//      all outputs 0 during and after reset; out_data=32'h23222120; no err_short.

Source files
------------

// File: rtl/tdm_demux.sv
// tdm_demux: receive end of a TDM channel stream.
//   Steers each valid sample into its channel slot (channel 0 is marked by in_sof).
//   A completed frame is presented on out_data with a one-cycle out_valid strobe.
// Parameters:
//   N_CH   channels per frame (>= 2)
//   WIDTH  bits per channel sample
// Ports:
//   clk        clock, posedge
//   rst        synchronous reset, active-high
//   in_valid   sample present this cycle
//   in_sof     sample is channel 0
//   in_data    channel sample
//   out_valid  one-cycle strobe, out_data holds a new frame
//   out_data   frame, channel k at [k*WIDTH +: WIDTH]
//   err_short  one-cycle pulse, in_sof arrived before the frame was complete
//   err_unfr   one-cycle pulse, non-sof sample while not in a frame
module tdm_demux #(
   parameter int unsigned N_CH  = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   input  logic                    in_sof,
   input  logic [WIDTH-1:0]        in_data,
   output logic                    out_valid,
   output logic [N_CH*WIDTH-1:0]   out_data,
   output logic                    err_short,
   output logic                    err_unfr
);

   localparam int unsigned SlotW = $clog2(N_CH);
   localparam logic [SlotW-1:0] LastSlot = SlotW'(N_CH - 1);
   localparam logic [SlotW-1:0] FirstSlot = SlotW'(1);

   typedef enum logic [0:0] {StIdle, StCollect} state_e;

   state_e           state_q;
   logic [SlotW-1:0] slot_q;
   logic [WIDTH-1:0] stage_q [N_CH];
   logic [N_CH*WIDTH-1:0] frame;

   // Completed frame: staged channels 0..N_CH-2 plus the sample arriving now.
   always_comb begin
      frame = '0;
      for (int k = 0; k < int'(N_CH) - 1; k++) begin
         frame[k*WIDTH +: WIDTH] = stage_q[k];
      end
      frame[(N_CH-1)*WIDTH +: WIDTH] = in_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         slot_q    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         err_short <= 1'b0;
         err_unfr  <= 1'b0;
         for (int k = 0; k < int'(N_CH); k++) begin
            stage_q[k] <= '0;
         end
      end else begin
         // Pulses default low so each event lasts exactly one cycle.
         out_valid <= 1'b0;
         err_short <= 1'b0;
         err_unfr  <= 1'b0;
         if (in_valid) begin
            unique case (state_q)
               StIdle: begin
                  if (in_sof) begin
                     stage_q[0] <= in_data;
                     slot_q     <= FirstSlot;
                     state_q    <= StCollect;
                  end else begin
                     err_unfr <= 1'b1;
                  end
               end
               StCollect: begin
                  if (in_sof) begin
                     // Short frame: drop partial data and restart on this sample.
                     err_short  <= 1'b1;
                     stage_q[0] <= in_data;
                     slot_q     <= FirstSlot;
                  end else begin
                     stage_q[slot_q] <= in_data;
                     if (slot_q == LastSlot) begin
                        out_data  <= frame;
                        out_valid <= 1'b1;
                        slot_q    <= '0;
                        state_q   <= StIdle;
                     end else begin
                        slot_q <= slot_q + FirstSlot;
                     end
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

endmodule
